// File: rtl/trigger_capture_ctrl_pkg.sv
// Shared types and constants for the trigger capture controller:
// FSM state encoding, trigger mode codes and a small state-class helper.
package trigger_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST_FILL = 3'd3,
        START_TX  = 3'd4,
        WAIT_TX   = 3'd5
    } state_t;

    localparam logic [1:0] LEVEL  = 2'b00;
    localparam logic [1:0] CHANGE = 2'b01;
    localparam logic [1:0] RISE   = 2'b10;
    localparam logic [1:0] FALL   = 2'b11;

    // True in the three states that write incoming samples to the buffer.
    function automatic logic is_capture(input state_t s);
        return (s == PRE_FILL) || (s == WAIT_TRIG) || (s == POST_FILL);
    endfunction

endpackage

// File: rtl/trigger_capture_ctrl_if.sv
// Control, probe and buffer-write bundle of the capture controller.
// Handshake: a sample is taken on every clk edge where sample_valid=1 (no back-pressure);
// stream_start is a one-cycle request, acknowledged by a one-cycle stream_done pulse.
interface trigger_capture_ctrl_if
    import trigger_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) ();

    logic                  arm;
    logic                  abort;
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] trig_mask;
    logic [DATA_WIDTH-1:0] trig_value;
    logic [1:0]            trig_mode;
    logic [ADDR_WIDTH-1:0] pretrig_len;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] trigger_index;
    logic                  stream_start;
    logic                  stream_done;
    logic                  busy;
    state_t                dbg_state;

    modport master (
        output arm, abort, sample_in, sample_valid, trig_mask, trig_value,
               trig_mode, pretrig_len, stream_done,
        input  wr_en, wr_addr, wr_data, trigger_index, stream_start, busy, dbg_state
    );

    modport slave (
        input  arm, abort, sample_in, sample_valid, trig_mask, trig_value,
               trig_mode, pretrig_len, stream_done,
        output wr_en, wr_addr, wr_data, trigger_index, stream_start, busy, dbg_state
    );

endinterface

// File: rtl/trigger_capture_ctrl_trigger_match.sv
// Trigger comparator: level match on the current sample, or edge detection
// against the previously accepted sample, restricted to masked bits.
module trigger_match
    import trigger_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic [DATA_WIDTH-1:0] i_prev,
    input  logic                  i_prev_valid,
    input  logic [DATA_WIDTH-1:0] i_mask,
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic [1:0]            i_mode,
    output logic                  o_fire
);

    logic [DATA_WIDTH-1:0] w_cur;
    logic [DATA_WIDTH-1:0] w_old;

    assign w_cur = i_sample & i_mask;
    assign w_old = i_prev & i_mask;

    // Edge modes need a previous sample, so they never fire on the first one after arm.
    always_comb begin
        o_fire = 1'b0;
        case (i_mode)
            LEVEL:   o_fire = (w_cur == (i_value & i_mask));
            CHANGE:  o_fire = i_prev_valid && (w_cur != w_old);
            RISE:    o_fire = i_prev_valid && (|(w_cur & ~w_old));
            FALL:    o_fire = i_prev_valid && (|(~w_cur & w_old));
            default: o_fire = 1'b0;
        endcase
    end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Logic-analyser capture controller: circular pre-trigger fill, trigger search,
// post-trigger fill, then a stream_start/stream_done handshake with the reader.
module trigger_capture_ctrl
    import trigger_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    trigger_capture_ctrl_if.slave cap
);

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;

    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_value;
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_pretrig;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_vld;
    logic [ADDR_WIDTH-1:0] r_trig_idx;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_accept;
    logic                  w_fire;
    logic                  w_trig_hit;
    logic                  w_arm_go;
    logic [ADDR_WIDTH-1:0] w_post_len;
    logic                  w_pre_last;
    logic                  w_post_last;

    // Abort wins over any sample arriving in the same cycle.
    assign w_accept    = is_capture(r_state) && cap.sample_valid && !cap.abort;
    assign w_arm_go    = (r_state == IDLE) && cap.arm;
    assign w_trig_hit  = (r_state == WAIT_TRIG) && w_accept && w_fire;
    // DEPTH-1-pretrig equals the bitwise complement within ADDR_WIDTH bits.
    assign w_post_len  = ~r_pretrig;
    assign w_pre_last  = (r_cnt == (r_pretrig - CNT_ONE));
    assign w_post_last = (r_cnt == (w_post_len - CNT_ONE));

    trigger_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trigger_match (
        .i_sample     (cap.sample_in),
        .i_prev       (r_prev),
        .i_prev_valid (r_prev_vld),
        .i_mask       (r_mask),
        .i_value      (r_value),
        .i_mode       (r_mode),
        .o_fire       (w_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if ((r_state != IDLE) && cap.abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cap.arm) begin
                        w_next_state = (cap.pretrig_len == '0) ? WAIT_TRIG : PRE_FILL;
                    end
                end
                PRE_FILL: begin
                    if (w_accept && w_pre_last) w_next_state = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (w_trig_hit) begin
                        w_next_state = (w_post_len == '0) ? START_TX : POST_FILL;
                    end
                end
                POST_FILL: begin
                    if (w_accept && w_post_last) w_next_state = START_TX;
                end
                START_TX: w_next_state = WAIT_TX;
                WAIT_TX: begin
                    if (cap.stream_done) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        cap.busy         = (r_state != IDLE);
        cap.stream_start = (r_state == START_TX) && !cap.abort && !rst;
        cap.dbg_state    = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask     <= '0;
            r_value    <= '0;
            r_mode     <= LEVEL;
            r_pretrig  <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_trig_idx <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_arm_go) begin
                r_mask     <= cap.trig_mask;
                r_value    <= cap.trig_value;
                r_mode     <= cap.trig_mode;
                r_pretrig  <= cap.pretrig_len;
                r_ptr      <= '0;
                r_cnt      <= '0;
                r_prev     <= '0;
                r_prev_vld <= 1'b0;
            end else if (w_accept) begin
                r_wr_addr  <= r_ptr;
                r_wr_data  <= cap.sample_in;
                r_ptr      <= r_ptr + CNT_ONE;
                r_prev     <= cap.sample_in;
                r_prev_vld <= 1'b1;
                if (r_state == PRE_FILL) begin
                    r_cnt <= w_pre_last ? '0 : (r_cnt + CNT_ONE);
                end else if (r_state == POST_FILL) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
            if (w_trig_hit) begin
                r_trig_idx <= r_ptr;
            end
        end
    end

    assign cap.wr_en         = r_wr_en;
    assign cap.wr_addr       = r_wr_addr;
    assign cap.wr_data       = r_wr_data;
    assign cap.trigger_index = r_trig_idx;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Self-checking bench for trigger_capture_ctrl (DATA_WIDTH=8, ADDR_WIDTH=4):
// directed scenarios plus randomized captures against an index-based capture model.
module tb_trigger_capture_ctrl;
  import trigger_capture_ctrl_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int W     = AW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trigger_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cap ();

  trigger_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .cap (cap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  logic [DW-1:0] stim_q[$];
  int            n_start;
  bit            mon_en = 1'b0;
  int            exp_tidx;
  int            exp_trig_i;
  bit            exp_done;

  // monitor: collect buffer writes and stream_start cycles away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (cap.wr_en) got_q.push_back({cap.wr_addr, cap.wr_data});
      if (cap.stream_start) n_start++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: sample i lands at address i mod DEPTH; first pretrig samples never trigger,
  // then the first matching sample triggers and DEPTH-1-pretrig more are written
  task automatic model_capture(input logic [1:0] mode, input logic [DW-1:0] mask,
                               input logic [DW-1:0] value, input int pretrig);
    int remain;
    bit fired;
    bit f;
    logic [DW-1:0] s;
    logic [DW-1:0] p;
    exp_q.delete();
    exp_done = 0; exp_tidx = 0; exp_trig_i = -1; fired = 0; remain = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      s = stim_q[i];
      exp_q.push_back({AW'(i % DEPTH), s});
      if (fired) begin
        remain--;
        if (remain == 0) begin exp_done = 1; break; end
      end else if (i >= pretrig) begin
        p = (i > 0) ? stim_q[i-1] : '0;
        case (mode)
          LEVEL:   f = ((s ^ value) & mask) == 0;
          CHANGE:  f = (i > 0) && (((s ^ p) & mask) != 0);
          RISE:    f = (i > 0) && ((s & ~p & mask) != 0);
          default: f = (i > 0) && ((~s & p & mask) != 0);
        endcase
        if (f) begin
          fired = 1; exp_trig_i = i; exp_tidx = i % DEPTH;
          remain = DEPTH - 1 - pretrig;
          if (remain == 0) begin exp_done = 1; break; end
        end
      end
    end
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [DW-1:0] mask,
                        input logic [DW-1:0] value, input int pretrig);
    cap.trig_mode   = mode;
    cap.trig_mask   = mask;
    cap.trig_value  = value;
    cap.pretrig_len = AW'(pretrig);
    cap.arm = 1'b1;
    tick();
    cap.arm = 1'b0;
    cap.trig_mode   = 2'($urandom_range(0, 3));
    cap.trig_mask   = DW'($urandom);
    cap.trig_value  = DW'($urandom);
    cap.pretrig_len = AW'($urandom);
  endtask

  task automatic drive_samples(input bit gaps);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        cap.sample_in = DW'($urandom);
        tick();
      end
      cap.sample_in    = stim_q[i];
      cap.sample_valid = 1'b1;
      tick();
      cap.sample_valid = 1'b0;
    end
  endtask

  task automatic run_capture(input logic [1:0] mode, input logic [DW-1:0] mask,
                             input logic [DW-1:0] value, input int pretrig,
                             input bit gaps, input bit finish);
    logic [DW-1:0] mem[DEPTH];
    int bad;
    int a;
    model_capture(mode, mask, value, pretrig);
    got_q.delete(); n_start = 0; mon_en = 1'b1;
    do_arm(mode, mask, value, pretrig);
    drive_samples(gaps);
    tick(); tick();
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL write_count: got %0d expected %0d", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL write[%0d]: got addr/data %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() !== exp_q.size()) n_fail++;
    n_checks++;
    if (n_start !== (exp_done ? 1 : 0)) begin
      n_fail++;
      $display("FAIL stream_start_cycles: got %0d expected %0d", n_start, exp_done ? 1 : 0);
    end
    n_checks++;
    if (cap.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_during_op: got %b expected 1", cap.busy);
    end
    if (exp_done) begin
      n_checks++;
      if (cap.trigger_index !== AW'(exp_tidx)) begin
        n_fail++;
        $display("FAIL trigger_index: got %0d expected %0d", cap.trigger_index, exp_tidx);
      end
      foreach (mem[k]) mem[k] = 'x;
      foreach (got_q[k]) mem[got_q[k][W-1:DW]] = got_q[k][DW-1:0];
      bad = 0;
      for (int j = 0; j < DEPTH; j++) begin
        a = (exp_tidx - pretrig + j + 2 * DEPTH) % DEPTH;
        if (mem[a] !== stim_q[exp_trig_i - pretrig + j]) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL frame_content: %0d of %0d words wrong, expected 0", bad, DEPTH);
      end
      if (finish) begin
        repeat ($urandom_range(1, 5)) tick();
        cap.stream_done = 1'b1;
        tick();
        cap.stream_done = 1'b0;
        n_checks++;
        if (cap.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_after_done: got %b expected 0", cap.busy);
        end
      end
    end else begin
      cap.abort = 1'b1;
      tick();
      cap.abort = 1'b0;
      n_checks++;
      if (cap.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_after_abort: got %b expected 0", cap.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cap.arm = 1'b0; cap.abort = 1'b0; cap.sample_valid = 1'b0; cap.stream_done = 1'b0;
    cap.sample_in = '0; cap.trig_mask = '0; cap.trig_value = '0; cap.trig_mode = LEVEL;
    cap.pretrig_len = '0;
    repeat (3) tick();
    n_checks++;
    if ({cap.wr_en, cap.wr_addr, cap.wr_data, cap.trigger_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_write_port: got en/addr/data/tidx %h expected 0",
               {cap.wr_en, cap.wr_addr, cap.wr_data, cap.trigger_index});
    end
    n_checks++;
    if (cap.stream_start !== 1'b0 || cap.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got start=%b busy=%b expected 0/0", cap.stream_start, cap.busy);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (cap.dbg_state !== IDLE || cap.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d busy=%b expected IDLE busy=0", cap.dbg_state, cap.busy);
    end
  endtask

  task automatic test_level_wrap();
    stim_q.delete();
    for (int i = 0; i < 32; i++) stim_q.push_back(DW'(8'h10 + i));
    run_capture(LEVEL, 8'hFF, 8'h20, 6, 1'b0, 1'b1);
    n_checks++;
    if (got_q.size() !== 26 || cap.trigger_index !== 4'd0) begin
      n_fail++;
      $display("FAIL level_wrap_totals: got writes=%0d tidx=%0d expected 26/0",
               got_q.size(), cap.trigger_index);
    end
  endtask

  task automatic test_rise();
    stim_q.delete();
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h01);
    for (int i = 0; i < 20; i++) stim_q.push_back(DW'($urandom));
    run_capture(RISE, 8'h01, 8'h00, 0, 1'b1, 1'b1);
    n_checks++;
    if (got_q.size() !== 17 || cap.trigger_index !== 4'd1) begin
      n_fail++;
      $display("FAIL rise_totals: got writes=%0d tidx=%0d expected 17/1",
               got_q.size(), cap.trigger_index);
    end
  endtask

  task automatic test_boundary_pretrig15();
    stim_q.delete();
    for (int i = 0; i < 15; i++) stim_q.push_back((i == 4) ? 8'h55 : DW'(i));
    stim_q.push_back(8'h10);
    stim_q.push_back(8'h55);
    for (int i = 0; i < 3; i++) stim_q.push_back(8'h33);
    run_capture(LEVEL, 8'hFF, 8'h55, 15, 1'b0, 1'b1);
    n_checks++;
    if (got_q.size() !== 17 || cap.trigger_index !== 4'd0) begin
      n_fail++;
      $display("FAIL pretrig15_totals: got writes=%0d tidx=%0d expected 17/0",
               got_q.size(), cap.trigger_index);
    end
  endtask

  task automatic test_abort();
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h02); stim_q.push_back(8'h03);
    model_capture(LEVEL, 8'hFF, 8'hAA, 2);
    got_q.delete(); n_start = 0; mon_en = 1'b1;
    do_arm(LEVEL, 8'hFF, 8'hAA, 2);
    drive_samples(1'b0);
    cap.sample_in = 8'hAA; cap.sample_valid = 1'b1; cap.abort = 1'b1;
    tick();
    cap.abort = 1'b0;
    repeat (3) tick();
    cap.sample_valid = 1'b0;
    tick();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL abort_writes: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    n_checks++;
    if (cap.busy !== 1'b0 || cap.dbg_state !== IDLE || n_start !== 0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b state=%0d starts=%0d expected 0/IDLE/0",
               cap.busy, cap.dbg_state, n_start);
    end
  endtask

  task automatic test_handshake();
    int bad;
    int nw;
    stim_q.delete();
    for (int i = 0; i < 32; i++) stim_q.push_back(DW'(8'h10 + i));
    run_capture(LEVEL, 8'hFF, 8'h20, 6, 1'b0, 1'b0);
    nw = got_q.size();
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) begin
        cap.trig_mode = LEVEL; cap.trig_mask = '0; cap.pretrig_len = '0; cap.arm = 1'b1;
      end else begin
        cap.arm = 1'b0;
      end
      cap.sample_in = DW'($urandom); cap.sample_valid = 1'b1;
      tick();
      if (cap.busy !== 1'b1 || cap.dbg_state !== WAIT_TX) bad++;
    end
    cap.sample_valid = 1'b0;
    n_checks++;
    if (bad != 0 || got_q.size() !== nw) begin
      n_fail++;
      $display("FAIL wait_tx_hold: got %0d bad cycles, writes %0d expected 0, %0d", bad, got_q.size(), nw);
    end
    cap.stream_done = 1'b1;
    tick();
    cap.stream_done = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (cap.busy !== 1'b0 || n_start !== 1) begin
      n_fail++;
      $display("FAIL handshake_end: got busy=%b starts=%0d expected 0/1", cap.busy, n_start);
    end
  endtask

  task automatic test_reset_mid_post();
    stim_q.delete();
    for (int i = 0; i < 7; i++) stim_q.push_back(DW'(8'h3C + i));
    got_q.delete(); n_start = 0;
    do_arm(LEVEL, 8'hFF, 8'h40, 3);
    drive_samples(1'b0);
    n_checks++;
    if (cap.dbg_state !== POST_FILL) begin
      n_fail++;
      $display("FAIL reach_post_fill: got %0d expected POST_FILL", cap.dbg_state);
    end
    rst = 1'b1; cap.sample_in = 8'h77; cap.sample_valid = 1'b1;
    tick();
    n_checks++;
    if ({cap.wr_en, cap.wr_addr, cap.wr_data, cap.trigger_index, cap.stream_start, cap.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_post: got en=%b addr=%0d data=%h tidx=%0d start=%b busy=%b expected all 0",
               cap.wr_en, cap.wr_addr, cap.wr_data, cap.trigger_index, cap.stream_start, cap.busy);
    end
    rst = 1'b0; cap.sample_valid = 1'b0;
    tick();
    stim_q.delete();
    for (int i = 0; i < 24; i++) stim_q.push_back(DW'($urandom_range(0, 7)));
    run_capture(CHANGE, 8'h07, 8'h00, 5, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0]    mode;
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    int pretrig;
    int n;
    for (int it = 0; it < 25; it++) begin
      mode    = 2'($urandom_range(0, 3));
      mask    = DW'($urandom_range(1, 255));
      pretrig = $urandom_range(0, 15);
      n       = pretrig + $urandom_range(4, 40);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(DW'($urandom) & DW'($urandom));
      value = ($urandom_range(0, 1) != 0) ? stim_q[$urandom_range(0, n - 1)] : DW'($urandom);
      run_capture(mode, mask, value, pretrig, 1'b1, 1'b1);
      repeat (2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_level_wrap();
    test_rise();
    test_boundary_pretrig15();
    test_abort();
    test_handshake();
    test_reset_mid_post();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
